// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential parametrised floating-point multiplier (shift-add significand, RNE rounding).
// Define FPMUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W + 1);
  localparam logic signed [E_W-1:0] BIAS    = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] EXP_MIN = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

  state_t                 state_reg;
  logic [W-1:0]           opa_reg, opb_reg, result_reg;
  logic                   in_ready_reg, out_valid_reg, sign_reg;
  logic [SIG_W-1:0]       mcand_reg, mplier_reg;
  logic [PROD_W-1:0]      acc_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic signed [E_W-1:0]  exp_reg;
  logic [MAN_W-1:0]       frac_reg;
  logic                   guard_reg, sticky_reg;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]             flags_reg;
`endif

  // Operand decode; exponent 0 covers both zero and flushed subnormals.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_next;
  assign ea = opa_reg[W-2 -: EXP_W];
  assign eb = opb_reg[W-2 -: EXP_W];
  assign fa = opa_reg[MAN_W-1:0];
  assign fb = opb_reg[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign sign_next = opa_reg[W-1] ^ opb_reg[W-1];

  logic signed [E_W-1:0] e_sum;
  logic [PROD_W-2:0]     prod_n;
  assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign prod_n = acc_reg[PROD_W-1] ? acc_reg[PROD_W-2:0] : {acc_reg[PROD_W-3:0], 1'b0};

  logic                  round_inc, ovf, unf;
  logic [MAN_W:0]        frac_rnd;
  logic signed [E_W-1:0] exp_rnd;
  assign round_inc = guard_reg & (sticky_reg | frac_reg[0]);
  assign frac_rnd  = {1'b0, frac_reg} + {{MAN_W{1'b0}}, round_inc};
  assign exp_rnd   = exp_reg + $signed({{(E_W-1){1'b0}}, frac_rnd[MAN_W]});
  assign ovf       = (exp_rnd >= EXP_MAX);
  assign unf       = (exp_rnd <= EXP_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      sign_reg      <= 1'b0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      exp_reg       <= '0;
      frac_reg      <= '0;
      guard_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
`ifdef FPMUL_FLAGS_EN
      flags_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          opa_reg      <= op_a;
          opb_reg      <= op_b;
          in_ready_reg <= 1'b0;
          state_reg    <= UNPACK;
        end
        UNPACK: begin
          sign_reg <= sign_next;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_reg    <= QNAN;
`ifdef FPMUL_FLAGS_EN
            flags_reg     <= 4'b1000;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else if (a_inf || b_inf || a_zero || b_zero) begin
            result_reg    <= (a_inf || b_inf) ? {sign_next, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                              : {sign_next, {(W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
            flags_reg     <= 4'b0000;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            mcand_reg  <= {1'b1, fa};
            mplier_reg <= {1'b1, fb};
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= MUL;
          end
        end
        MUL: begin
          if (mplier_reg[cnt_reg])
            acc_reg <= acc_reg + ({{SIG_W{1'b0}}, mcand_reg} << cnt_reg);
          if (cnt_reg == CNT_W'(MAN_W)) state_reg <= NORM;
          else                          cnt_reg   <= cnt_reg + 1'b1;
        end
        NORM: begin
          exp_reg    <= e_sum + $signed({{(E_W-1){1'b0}}, acc_reg[PROD_W-1]});
          frac_reg   <= prod_n[PROD_W-2 -: MAN_W];
          guard_reg  <= prod_n[PROD_W-2-MAN_W];
          sticky_reg <= |prod_n[PROD_W-3-MAN_W:0];
          state_reg  <= ROUND;
        end
        ROUND: begin
          if (ovf)      result_reg <= {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else if (unf) result_reg <= {sign_reg, {(W-1){1'b0}}};
          else          result_reg <= {sign_reg, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
`ifdef FPMUL_FLAGS_EN
          flags_reg     <= {1'b0, ovf, unf, guard_reg | sticky_reg | ovf | unf};
`endif
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
`ifdef FPMUL_FLAGS_EN
  assign flags     = flags_reg;
`endif

endmodule

// File: tb/tb_fp_mul_seq.sv
// Testbench for fp_mul_seq: vector table plus scoreboard queue, back-pressure and mid-MUL reset sequences.
// Flags are checked when FPMUL_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_fp_mul_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NV    = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] op_a = '0, op_b = '0, result;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]   flags;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result)
`ifdef FPMUL_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic [3:0] flg, input int lat, input int hold);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    e.res = res;
    e.flg = flg;
    e.lat = lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("out_valid", {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("latency", cyc, e.lat);
    check("result", result, e.res);
`ifdef FPMUL_FLAGS_EN
    check("flags", {28'd0, flags}, {28'd0, e.flg});
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", result, e.res);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef FPMUL_FLAGS_EN
      check("hold_flags", {28'd0, flags}, {28'd0, e.flg});
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    $display("op %h * %h -> %h (want %h, flags %b) latency %0d hold %0d", a, b, result, e.res, e.flg, cyc, hold);
  endtask

  initial begin
    int saw;
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28};
    vecs[1]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, 28};
    vecs[2]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28};
    vecs[4]  = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001, 28};
    vecs[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 28};
    vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 28};
    vecs[7]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 28};
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2};
    vecs[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2};
    vecs[10] = '{32'h00000001, 32'hC0000000, 32'h80000000, 4'b0000, 2};
    vecs[11] = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 28};
    vecs[12] = '{32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 4'b0000, 28};
    vecs[13] = '{32'h80800000, 32'h00800000, 32'h80000000, 4'b0011, 28};
    vecs[14] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
`ifdef FPMUL_FLAGS_EN
    check("reset_flags", {28'd0, flags}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < NV; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].lat, 0);

    // Back-pressure on a normal and a special result
    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 5);
    do_op(32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2, 3);

    // Abort an operation while it is iterating in MUL
    op_a = 32'h3FC00000;
    op_b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1;
    end
    check("abort_silent", saw, 32'd0);
    $display("reset during MUL: in_ready %b out_valid %b result %h", in_ready, out_valid, result);

    do_op(32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, 28, 0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Parametrised sequential floating-point multiplier.
- Successor to the fixed FP32 multiply datapath. Exponent and mantissa widths are generic, with round-to-nearest-even, special-value handling, overflow/underflow saturation and a valid/ready handshake on both sides.
- Significand product is built with a radix-2 shift-add iteration, one partial product per clock.
- Sits between operand registers and the result bus of the arithmetic unit.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width; the significand is MAN_W+1 bits including the hidden 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- op_a  input  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
- op_b  input  1+EXP_W+MAN_W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  1+EXP_W+MAN_W  product.
- flags  output  4  {invalid, overflow, underflow, inexact}; present only with FPMUL_FLAGS_EN.

Behaviour:
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0. Asserting reset in any state aborts the operation in flight; nothing is emitted.
- FSM states: IDLE -> UNPACK -> MUL -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, capture op_a/op_b and go to UNPACK. in_ready=0 in every other state.
- UNPACK (1 cycle):
  - sign = sa^sb.
  - Subnormal inputs (exp=0, frac!=0) are flushed to zero, keeping their sign.
  - Special cases go straight to DONE:
    - any NaN, or inf*0 -> canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
    - inf*finite nonzero -> {sign, all-ones, 0}.
    - zero*finite -> {sign, 0, 0}.
  - Otherwise: load the significands {1,frac}, clear the 2*(MAN_W+1)-bit accumulator, set the iteration counter to 0, go to MUL.
- MUL (MAN_W+1 cycles):
  - Each cycle, if multiplier bit[cnt]=1, add the multiplicand shifted by cnt into the accumulator.
  - Leave MUL when cnt = MAN_W.
- NORM (1 cycle):
  - Exponent sum e = ea + eb - BIAS, computed as signed EXP_W+2 bits.
  - If product MSB=1: mantissa window = bits below the MSB, e+1.
  - Else: window one bit lower.
  - Form guard bit and sticky (OR of all lower bits).
- ROUND (1 cycle), round-to-nearest-even:
  - Increment if guard & (sticky | lsb).
  - A carry-out of the fraction sets frac=0 and e+1.
  - inexact = guard|sticky.
  - If e >= 2^EXP_W-1: result = {sign, all-ones, 0}, overflow=1, inexact=1.
  - If e <= 0: result = {sign, 0, 0}, underflow=1 (flush to zero), inexact=1.
- DONE: out_valid=1. result and flags are held stable until out_ready=1; on that cycle go to IDLE and drop out_valid. No operand is accepted in the same cycle as DONE exits; the next accept is possible one cycle later.
- Latency from accept edge to out_valid high:
  - Normal operands: MAN_W+5 cycles (28 for defaults).
  - Specials: 2 cycles.
- Throughput is one operation in flight; result registers update only on transition into DONE.

Optional Feature:
- FPMUL_FLAGS_EN defined: the 4-bit flags port exists and is registered alongside result, with reset value 0.
- FPMUL_FLAGS_EN undefined: no flags port and no flag logic; result behaviour is identical.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> result 0x40400000 after 28 cycles; with flags, flags=0.
- 0xBFC00000 * 0x40000000 -> 0xC0400000; 0x00000000 * 0x7F800000 -> 0x7FC00000 after 2 cycles, invalid=1.
- Rounding:
  - 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1.
  - Tie case 0x3F800800 * 0x3F800800 -> 0x3F801000 (even kept), inexact=1.
- Range limits:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1.
  - 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result, flags and out_valid stable; in_ready stays 0; accept completes on the out_ready cycle.
- Assert reset during MUL (cycle 10) -> next cycle in_ready=1, out_valid=0, result=0; a new operation then completes correctly.
